// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between two Avalon-style masters, the arbiter and a single-port RAM.
// The arbiter takes the slave view; the masters and RAM side take the master view.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_lock;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_lock;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write,
        input  m0_writedata, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write,
        input  m1_writedata, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write,
        output m0_writedata, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write,
        output m1_writedata, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter with bounded grant locking in front of a
// single-port on-chip RAM; one access per cycle, fixed one-cycle read latency.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 7500,
    parameter int LOCK_MAX  = 16
) (
    input  logic clk,
    input  logic reset_n,
    onchip_mem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED0,
        LOCKED1
    } lock_state_e;

    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        rst_sync_q, rst_sync_d;

    logic              pend_v_q, pend_v_d;
    logic              pend_id_q, pend_id_d;
    logic              pend_oor_q, pend_oor_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic              rdy;
    logic              req0, req1;
    logic              oor0, oor1;
    logic              at_max;
    logic              gnt0, gnt1, gnt;
    logic              sel_wr, sel_oor;
    logic [DATA_W-1:0] rd_data;

    // Grants stay off until the release of reset has crossed two flops.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rdy        = rst_sync_q[1];

    assign req0   = rdy & (bus.m0_read | bus.m0_write);
    assign req1   = rdy & (bus.m1_read | bus.m1_write);
    assign oor0   = {1'b0, bus.m0_address} >= DEPTH;
    assign oor1   = {1'b0, bus.m1_address} >= DEPTH;
    assign at_max = (lock_cnt_q == CNT_MAX);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            unique case (state_q)
                LOCKED0: begin
                    gnt0 = ~at_max;
                    gnt1 = at_max;
                end
                LOCKED1: begin
                    gnt1 = ~at_max;
                    gnt0 = at_max;
                end
                default: begin
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end
            endcase
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign gnt = gnt0 | gnt1;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
        unique case (state_q)
            LOCKED0: begin
                if (!req0 || (gnt0 && !bus.m0_lock)) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else if (gnt1) begin
                    lock_cnt_d = '0;
                end else if (req1) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
            LOCKED1: begin
                if (!req1 || (gnt1 && !bus.m1_lock)) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else if (gnt0) begin
                    lock_cnt_d = '0;
                end else if (req0) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
            default: begin
                lock_cnt_d = '0;
                if (gnt0 && bus.m0_lock) begin
                    state_d = LOCKED0;
                end else if (gnt1 && bus.m1_lock) begin
                    state_d = LOCKED1;
                end
            end
        endcase
    end

    // Idle cycles keep the RAM-side address/data at the last granted values.
    always_comb begin
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        sel_wr  = 1'b0;
        sel_oor = 1'b0;
        if (gnt0) begin
            addr_d  = bus.m0_address;
            be_d    = bus.m0_byteenable;
            wd_d    = bus.m0_writedata;
            sel_wr  = bus.m0_write;
            sel_oor = oor0;
        end else if (gnt1) begin
            addr_d  = bus.m1_address;
            be_d    = bus.m1_byteenable;
            wd_d    = bus.m1_writedata;
            sel_wr  = bus.m1_write;
            sel_oor = oor1;
        end
    end

    assign pend_v_d   = gnt & ~sel_wr;
    assign pend_id_d  = gnt1;
    assign pend_oor_d = sel_oor;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= UNLOCKED;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rst_sync_q   <= '0;
            pend_v_q     <= 1'b0;
            pend_id_q    <= 1'b0;
            pend_oor_q   <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rst_sync_q   <= rst_sync_d;
            pend_v_q     <= pend_v_d;
            pend_id_q    <= pend_id_d;
            pend_oor_q   <= pend_oor_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wd_q         <= wd_d;
        end
    end

    assign bus.mem_address    = addr_d;
    assign bus.mem_byteenable = be_d;
    assign bus.mem_writedata  = wd_d;
    assign bus.mem_chipselect = gnt & ~sel_oor;
    assign bus.mem_write      = gnt & sel_wr;
    assign bus.mem_clken      = reset_n;

    assign bus.m0_waitrequest = ~gnt0;
    assign bus.m1_waitrequest = ~gnt1;

    // Out-of-range reads never touched the RAM, so their data is forced to zero.
    assign rd_data = pend_oor_q ? '0 : bus.mem_readdata;

    assign bus.m0_readdatavalid = pend_v_q & ~pend_id_q;
    assign bus.m1_readdatavalid = pend_v_q & pend_id_q;
    assign bus.m0_readdata = bus.m0_readdatavalid ? rd_data : '0;
    assign bus.m1_readdata = bus.m1_readdatavalid ? rd_data : '0;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model, shadow memory and read scoreboard,
// with one task per scenario.
module tb_onchip_mem_arbiter;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 7500;
    localparam int LOCK_MAX  = 16;
    localparam logic [119:0] RST_SNAP = {2'b11, 118'h0};

    typedef struct {
        int          m;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    typedef struct {
        int          m;
        logic        wr;
        logic [12:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } op_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .NUM_WORDS(NUM_WORDS),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    sb_t sbq[$];

    logic [31:0] ram [0:8191];
    logic [31:0] shadow [0:8191];
    logic [12:0] ram_addr_q = '0;
    logic        ram_init = 1'b0;
    logic        sh_init = 1'b0;

    function automatic logic [31:0] pattern(input int i);
        return 32'hA5000000 | 32'(i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with registered address and unregistered q.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 8192; i++) ram[i] <= pattern(i);
            ram_init <= 1'b1;
        end else if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b])
                        ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end
            ram_addr_q <= bus.mem_address;
        end
    end
    assign bus.mem_readdata = ram[ram_addr_q];

    // Scoreboard: pop on readdatavalid, push on every accepted read.
    always @(negedge clk) begin
        sb_t e;
        logic [1:0] v;
        logic [31:0] rd;
        int am;
        logic acc, aw, ar;
        logic [12:0] aa;
        logic [3:0] ab;
        logic [31:0] ad;
        if (!sh_init) begin
            for (int i = 0; i < 8192; i++) shadow[i] <= pattern(i);
            sh_init <= 1'b1;
        end
        v = {bus.m1_readdatavalid, bus.m0_readdatavalid};
        rd = v[1] ? bus.m1_readdata : bus.m0_readdata;
        n_chk++;
        if ((!v[0] && bus.m0_readdata !== 32'h0) || (!v[1] && bus.m1_readdata !== 32'h0))
            $display("FAIL rd_zero: m0=%h m1=%h v=%b required zero when not valid",
                     bus.m0_readdata, bus.m1_readdata, v);
        else n_pass++;
        n_chk++;
        if (!bus.m0_waitrequest && !bus.m1_waitrequest)
            $display("FAIL one_grant: both waitrequest low at cycle %0d, required at most one", cyc);
        else n_pass++;
        if (v != 2'b00) begin
            n_chk++;
            if (sbq.size() == 0) begin
                $display("FAIL sb_unexpected: readdatavalid=%b at cycle %0d, required none", v, cyc);
            end else begin
                e = sbq.pop_front();
                if (v !== (2'b01 << e.m) || rd !== e.data || cyc != e.cyc)
                    $display("FAIL sb_read: valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                             v, rd, cyc, 2'b01 << e.m, e.data, e.cyc);
                else n_pass++;
            end
        end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            n_chk++;
            $display("FAIL sb_missing: no readdatavalid at cycle %0d, required m%0d data=%h",
                     cyc, sbq[0].m, sbq[0].data);
            void'(sbq.pop_front());
        end
        acc = 1'b0; aw = 1'b0; ar = 1'b0; am = 0; aa = '0; ab = '0; ad = '0;
        if (!bus.m0_waitrequest) begin
            acc = 1'b1; am = 0; aw = bus.m0_write; ar = bus.m0_read;
            aa = bus.m0_address; ab = bus.m0_byteenable; ad = bus.m0_writedata;
        end else if (!bus.m1_waitrequest) begin
            acc = 1'b1; am = 1; aw = bus.m1_write; ar = bus.m1_read;
            aa = bus.m1_address; ab = bus.m1_byteenable; ad = bus.m1_writedata;
        end
        if (acc && aw) begin
            if (int'(aa) < NUM_WORDS)
                for (int b = 0; b < 4; b++)
                    if (ab[b]) shadow[aa][8*b +: 8] <= ad[8*b +: 8];
        end else if (acc && ar) begin
            sbq.push_back('{m: am,
                            data: (int'(aa) < NUM_WORDS) ? shadow[aa] : 32'h0,
                            cyc: cyc + 1});
        end
    end

    function automatic logic [119:0] snap();
        return {bus.m0_waitrequest, bus.m1_waitrequest,
                bus.m0_readdatavalid, bus.m1_readdatavalid,
                bus.m0_readdata, bus.m1_readdata,
                bus.mem_chipselect, bus.mem_write, bus.mem_clken,
                bus.mem_address, bus.mem_byteenable, bus.mem_writedata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic rd, input logic wr,
                         input logic [12:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic lk);
        if (m == 0) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
            bus.m0_byteenable = be; bus.m0_writedata = d; bus.m0_lock = lk;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
            bus.m1_byteenable = be; bus.m1_writedata = d; bus.m1_lock = lk;
        end
    endtask

    task automatic idle();
        set_m(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    endtask

    // Issue one access, wait for acceptance, return at posedge+1 of the next cycle.
    task automatic do_access(input int m, input logic wr, input logic [12:0] a,
                             input logic [3:0] be, input logic [31:0] d,
                             input string name);
        bit done = 0;
        logic exp_cs;
        set_m(m, !wr, wr, a, be, d, 1'b0);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((m == 0 ? bus.m0_waitrequest : bus.m1_waitrequest) == 1'b0) begin
                done = 1;
                exp_cs = int'(a) < NUM_WORDS;
                n_chk++;
                if (bus.mem_chipselect !== exp_cs || bus.mem_address !== a ||
                    (exp_cs && bus.mem_write !== wr) ||
                    (wr && (bus.mem_byteenable !== be || bus.mem_writedata !== d)))
                    $display("FAIL %s_bus: cs=%b we=%b addr=%0d be=%h wd=%h, required cs=%b we=%b addr=%0d",
                             name, bus.mem_chipselect, bus.mem_write, bus.mem_address,
                             bus.mem_byteenable, bus.mem_writedata, exp_cs, wr, a);
                else n_pass++;
            end
            tick();
        end
        set_m(m, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
        n_chk++;
        if (!done) $display("FAIL %s_timeout: waitrequest stayed 1, required accept within 20 cycles", name);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle();
        #2 reset_n = 1'b0;
        set_m(0, 1'b1, 1'b0, 13'd3, 4'hF, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b1, 13'd4, 4'hF, 32'hCAFE0004, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (snap() !== RST_SNAP) $display("FAIL reset_outputs: got %h required %h", snap(), RST_SNAP);
        else n_pass++;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.m0_waitrequest, bus.m1_waitrequest, bus.mem_clken} !== 3'b111)
            $display("FAIL rst_release0: wr/clken=%b required 111",
                     {bus.m0_waitrequest, bus.m1_waitrequest, bus.mem_clken});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b11)
            $display("FAIL rst_release1: waitrequest=%b required 11 after first edge",
                     {bus.m0_waitrequest, bus.m1_waitrequest});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b01)
            $display("FAIL first_conflict: waitrequest=%b required 01 (m0 wins)",
                     {bus.m0_waitrequest, bus.m1_waitrequest});
        else n_pass++;
        tick();
        set_m(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (bus.m1_waitrequest !== 1'b0) $display("FAIL single_req: m1_waitrequest=1 required 0");
        else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_partial_write();
        tick();
        do_access(0, 1'b1, 13'd0, 4'hF, 32'hFFFFFFFF, "pw_fill");
        do_access(0, 1'b1, 13'd0, 4'h3, 32'h12345678, "pw_part");
        do_access(0, 1'b0, 13'd0, 4'hF, 32'h0, "pw_read");
        @(negedge clk);
        n_chk++;
        if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hFFFF5678)
            $display("FAIL partial_write: valid=%b data=%h required 1 FFFF5678",
                     bus.m0_readdatavalid, bus.m0_readdata);
        else n_pass++;
    endtask

    task automatic test_write_read();
        tick();
        do_access(0, 1'b1, 13'd5, 4'hF, 32'hDEADBEEF, "wr_m0");
        do_access(1, 1'b0, 13'd5, 4'hF, 32'h0, "rd_m1");
        @(negedge clk);
        n_chk++;
        if ({bus.m1_readdatavalid, bus.m0_readdatavalid} !== 2'b10 || bus.m1_readdata !== 32'hDEADBEEF)
            $display("FAIL write_read: valid=%b data=%h required 10 DEADBEEF",
                     {bus.m1_readdatavalid, bus.m0_readdatavalid}, bus.m1_readdata);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        tick();
        do_access(1, 1'b1, 13'd7500, 4'hF, 32'h55AA55AA, "oor_wr");
        do_access(1, 1'b0, 13'd7500, 4'hF, 32'h0, "oor_rd");
        @(negedge clk);
        n_chk++;
        if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h0)
            $display("FAIL oor_read: valid=%b data=%h required 1 00000000",
                     bus.m1_readdatavalid, bus.m1_readdata);
        else n_pass++;
        tick();
        do_access(1, 1'b1, 13'd7499, 4'hF, 32'h0BADF00D, "edge_wr");
        do_access(1, 1'b0, 13'd7499, 4'hF, 32'h0, "edge_rd");
        @(negedge clk);
        n_chk++;
        if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h0BADF00D)
            $display("FAIL last_word: valid=%b data=%h required 1 0BADF00D",
                     bus.m1_readdatavalid, bus.m1_readdata);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int c0 = 0;
        int c1 = 0;
        tick();
        set_m(0, 1'b1, 1'b0, 13'd10, 4'hF, 32'h0, 1'b0);
        set_m(1, 1'b1, 1'b0, 13'd20, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                n_chk++;
                if ({bus.m0_waitrequest, bus.m1_waitrequest} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                    $display("FAIL rr_grant%0d: waitrequest=%b required %b", i,
                             {bus.m0_waitrequest, bus.m1_waitrequest},
                             (i % 2 == 0) ? 2'b01 : 2'b10);
                else n_pass++;
            end
            if (i > 0) begin
                c0 += int'(bus.m0_readdatavalid);
                c1 += int'(bus.m1_readdatavalid);
            end
            tick();
            if (i == 7) idle();
        end
        n_chk++;
        if (c0 != 4 || c1 != 4) $display("FAIL rr_valids: m0=%0d m1=%0d required 4 4", c0, c1);
        else n_pass++;
    endtask

    task automatic test_lock();
        tick();
        set_m(0, 1'b1, 1'b0, 13'd30, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        n_chk++;
        if (bus.m0_waitrequest !== 1'b0) $display("FAIL lock_take: m0_waitrequest=1 required 0");
        else n_pass++;
        tick();
        set_m(1, 1'b1, 1'b0, 13'd40, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.m0_waitrequest, bus.m1_waitrequest} !== ((i == LOCK_MAX) ? 2'b10 : 2'b01))
                $display("FAIL lock_grant%0d: waitrequest=%b required %b", i,
                         {bus.m0_waitrequest, bus.m1_waitrequest},
                         (i == LOCK_MAX) ? 2'b10 : 2'b01);
            else n_pass++;
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        op_t ops[8];
        ops[0] = '{0, 1'b1, 13'd100, 4'hF, 32'h11112222};
        ops[1] = '{1, 1'b0, 13'd100, 4'hF, 32'h0};
        ops[2] = '{0, 1'b0, 13'd100, 4'hF, 32'h0};
        ops[3] = '{1, 1'b1, 13'd101, 4'hC, 32'h33334444};
        ops[4] = '{0, 1'b0, 13'd101, 4'hF, 32'h0};
        ops[5] = '{1, 1'b0, 13'd100, 4'hF, 32'h0};
        ops[6] = '{0, 1'b0, 13'd101, 4'hF, 32'h0};
        ops[7] = '{1, 1'b0, 13'd7500, 4'hF, 32'h0};
        tick();
        for (int i = 0; i < 8; i++) begin
            idle();
            set_m(ops[i].m, !ops[i].wr, ops[i].wr, ops[i].a, ops[i].be, ops[i].d, 1'b0);
            @(negedge clk);
            n_chk++;
            if ((ops[i].m == 0 ? bus.m0_waitrequest : bus.m1_waitrequest) !== 1'b0)
                $display("FAIL b2b_grant%0d: waitrequest=1 required 0", i);
            else n_pass++;
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        int nv = 0;
        tick();
        set_m(0, 1'b1, 1'b0, 13'd200, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (bus.m0_waitrequest !== 1'b0) $display("FAIL inflight_grant: m0_waitrequest=1 required 0");
        else n_pass++;
        tick();
        reset_n = 1'b0;
        sbq.delete();
        set_m(1, 1'b1, 1'b0, 13'd9, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (snap() !== RST_SNAP) $display("FAIL inflight_reset: got %h required %h", snap(), RST_SNAP);
        else n_pass++;
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nv += int'(bus.m0_readdatavalid);
        end
        n_chk++;
        if (nv != 0) $display("FAIL inflight_valid: %0d m0 valid pulses after reset, required 0", nv);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_partial_write();
        test_write_read();
        test_out_of_range();
        test_round_robin();
        test_lock();
        test_back_to_back();
        test_reset_inflight();
        tick();
        n_chk++;
        if (sbq.size() != 0) $display("FAIL sb_leftover: %0d reads outstanding, required 0", sbq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
